uart_rx_byte: RTL and testbench

- 8N1 UART receiver. Deserialises the FTDI serial line on the board into bytes.
- Sits directly upstream of the command decoder: drives its `rx_byte` bus and its one-cycle `received` strobe.
- The decoder turns these bytes into the DDS tuning word and its set/enable controls.
- Runs on the 12 MHz system clock, with a 2-flop synchroniser on the asynchronous pin.

---
 rtl/uart_rx_byte.sv | 126 ++++++++++++
 tb/tb_uart_rx_byte.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receiver feeding the command decoder.
// Start edge, start-bit mid-sample, eight LSB-first data bits, stop-bit check.
module uart_rx_byte #(
   parameter int CLKS_PER_BIT = 104,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       received,
   output logic       frame_err,
   output logic       busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [7:0]    shift, shift_n;
   logic [7:0]    byte_n;
   logic          received_n, frame_err_n;
   logic          rx_meta, rx_s;

   // Sync flops preset high so reset never looks like a start edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         rx_byte   <= '0;
         received  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         bit_idx   <= bit_idx_n;
         shift     <= shift_n;
         rx_byte   <= byte_n;
         received  <= received_n;
         frame_err <= frame_err_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      bit_idx_n   = bit_idx;
      shift_n     = shift;
      byte_n      = rx_byte;
      received_n  = 1'b0;
      frame_err_n = 1'b0;
      case (state)
         S_IDLE: begin
            cnt_n     = '0;
            bit_idx_n = '0;
            if (!rx_s) state_n = S_START;
         end
         S_START: begin
            if (cnt == HALF_LAST) begin
               cnt_n     = '0;
               bit_idx_n = '0;
               state_n   = rx_s ? S_IDLE : S_DATA;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         S_DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_n            = '0;
               shift_n[bit_idx] = rx_s;
               if (bit_idx == 3'd7) state_n = S_STOP;
               else bit_idx_n = bit_idx + 3'd1;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         S_STOP: begin
            // Leaving at mid-stop gives half a bit of slack for the next start edge.
            if (cnt == BIT_LAST) begin
               cnt_n = '0;
               if (rx_s) begin
                  byte_n     = shift;
                  received_n = 1'b1;
                  state_n    = S_IDLE;
               end else begin
                  frame_err_n = 1'b1;
                  state_n     = S_BREAK;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         S_BREAK: begin
            cnt_n = '0;
            if (rx_s) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - self-checking bench for uart_rx_byte.
// A cycle-level line driver plus an event log checked against expected bytes and timing.
module tb_uart_rx_byte;

   localparam int CPB     = 104;
   localparam int HALF    = CPB / 2;
   localparam int LAT     = 2 + 1 + HALF + 9 * CPB;
   localparam int NOLIMIT = 1 << 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] rx_byte;
   logic       received;
   logic       frame_err;
   logic       busy;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int overlap = 0;

   int         rcv_cyc[$];
   logic [7:0] rcv_byte[$];
   int         ferr_cyc[$];

   always #5 clk = ~clk;

   uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rx(rx),
      .rx_byte(rx_byte),
      .received(received),
      .frame_err(frame_err),
      .busy(busy)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (received) begin
         rcv_cyc.push_back(cyc);
         rcv_byte.push_back(rx_byte);
      end
      if (frame_err) ferr_cyc.push_back(cyc);
      if (received && frame_err) overlap++;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_events();
      rcv_cyc.delete();
      rcv_byte.delete();
      ferr_cyc.delete();
   endtask

   // Drives start, 8 data bits LSB first, stop; optionally cut short after max_cycles.
   task automatic drive_frame(input logic [7:0] d, input int period, input logic stop_lvl,
                              input int max_cycles, output int start_cyc);
      logic [9:0] bits;
      bits = {stop_lvl, d, 1'b0};
      start_cyc = cyc;
      for (int c = 0; c < 10 * period && c < max_cycles; c++) begin
         rx = bits[c / period];
         tick(1);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rx = 1'b1;
      tick(3);
      vectors++;
      if (rx_byte !== 8'h00) begin miscompares++; $display("FAIL reset_rx_byte: got %h expected 00", rx_byte); end
      vectors++;
      if (received !== 1'b0) begin miscompares++; $display("FAIL reset_received: got %b expected 0", received); end
      vectors++;
      if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
      rst_n = 1'b1;
      tick(5);
   endtask

   task automatic test_single();
      int s;
      int lat;
      clear_events();
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_before: got %b expected 0", busy); end
      fork
         drive_frame(8'hA5, CPB, 1'b1, NOLIMIT, s);
         begin
            tick(500);
            vectors++;
            if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_mid: got %b expected 1", busy); end
         end
      join
      tick(100);
      vectors++;
      if (rcv_cyc.size() !== 1) begin miscompares++; $display("FAIL single_count: got %0d expected 1", rcv_cyc.size()); end
      if (rcv_cyc.size() >= 1) begin
         vectors++;
         if (rcv_byte[0] !== 8'hA5) begin miscompares++; $display("FAIL single_byte: got %h expected a5", rcv_byte[0]); end
         lat = rcv_cyc[0] - s;
         vectors++;
         if (lat < LAT - 1 || lat > LAT + 1) begin miscompares++; $display("FAIL single_latency: got %0d expected %0d+-1", lat, LAT); end
      end
      vectors++;
      if (ferr_cyc.size() !== 0) begin miscompares++; $display("FAIL single_frame_err: got %0d expected 0", ferr_cyc.size()); end
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_after: got %b expected 0", busy); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp[4];
      int s;
      int d;
      exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h2A; exp[3] = 8'h67;
      clear_events();
      for (int i = 0; i < 4; i++) drive_frame(exp[i], CPB, 1'b1, NOLIMIT, s);
      tick(100);
      vectors++;
      if (rcv_cyc.size() !== 4) begin miscompares++; $display("FAIL b2b_count: got %0d expected 4", rcv_cyc.size()); end
      for (int i = 0; i < 4 && i < rcv_cyc.size(); i++) begin
         vectors++;
         if (rcv_byte[i] !== exp[i]) begin miscompares++; $display("FAIL b2b_byte%0d: got %h expected %h", i, rcv_byte[i], exp[i]); end
         if (i > 0) begin
            d = rcv_cyc[i] - rcv_cyc[i-1];
            vectors++;
            if (d < 10 * CPB - 1 || d > 10 * CPB + 1) begin miscompares++; $display("FAIL b2b_spacing%0d: got %0d expected %0d+-1", i, d, 10 * CPB); end
         end
      end
      vectors++;
      if (ferr_cyc.size() !== 0) begin miscompares++; $display("FAIL b2b_frame_err: got %0d expected 0", ferr_cyc.size()); end
   endtask

   task automatic test_glitch();
      int s;
      clear_events();
      rx = 1'b0;
      tick(20);
      rx = 1'b1;
      tick(10);
      vectors++;
      if (busy !== 1'b1) begin miscompares++; $display("FAIL glitch_busy_mid: got %b expected 1", busy); end
      tick(28);
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_busy_end: got %b expected 0", busy); end
      vectors++;
      if (rcv_cyc.size() + ferr_cyc.size() !== 0) begin miscompares++; $display("FAIL glitch_events: got %0d expected 0", rcv_cyc.size() + ferr_cyc.size()); end
      drive_frame(8'h3C, CPB, 1'b1, NOLIMIT, s);
      tick(100);
      vectors++;
      if (rcv_cyc.size() !== 1 || rx_byte !== 8'h3C) begin miscompares++; $display("FAIL glitch_next: got %0d pulses byte %h expected 1 pulse byte 3c", rcv_cyc.size(), rx_byte); end
   endtask

   task automatic test_break();
      int s;
      clear_events();
      drive_frame(8'h11, CPB, 1'b1, NOLIMIT, s);
      tick(50);
      drive_frame(8'h55, CPB, 1'b0, NOLIMIT, s);
      tick(2000);
      rx = 1'b1;
      tick(100);
      vectors++;
      if (ferr_cyc.size() !== 1) begin miscompares++; $display("FAIL break_ferr_count: got %0d expected 1", ferr_cyc.size()); end
      if (ferr_cyc.size() >= 1) begin
         vectors++;
         if (ferr_cyc[0] - s < LAT - 1 || ferr_cyc[0] - s > LAT + 1) begin miscompares++; $display("FAIL break_ferr_time: got %0d expected %0d+-1", ferr_cyc[0] - s, LAT); end
      end
      vectors++;
      if (rcv_cyc.size() !== 1) begin miscompares++; $display("FAIL break_rcv_count: got %0d expected 1", rcv_cyc.size()); end
      vectors++;
      if (rx_byte !== 8'h11) begin miscompares++; $display("FAIL break_rx_byte: got %h expected 11", rx_byte); end
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL break_busy: got %b expected 0", busy); end
      clear_events();
      drive_frame(8'h99, CPB, 1'b1, NOLIMIT, s);
      tick(100);
      vectors++;
      if (rcv_cyc.size() !== 1 || rx_byte !== 8'h99) begin miscompares++; $display("FAIL break_next: got %0d pulses byte %h expected 1 pulse byte 99", rcv_cyc.size(), rx_byte); end
   endtask

   task automatic test_reset_mid();
      int s;
      clear_events();
      drive_frame(8'hC3, CPB, 1'b1, 5 * CPB + CPB / 2, s);
      rst_n = 1'b0;
      tick(1);
      vectors++;
      if (rx_byte !== 8'h00 || received !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rstmid_outputs: got byte %h rcv %b ferr %b busy %b expected 00 0 0 0", rx_byte, received, frame_err, busy);
      end
      rx = 1'b1;
      rst_n = 1'b1;
      tick(1200);
      vectors++;
      if (rcv_cyc.size() + ferr_cyc.size() !== 0) begin miscompares++; $display("FAIL rstmid_events: got %0d expected 0", rcv_cyc.size() + ferr_cyc.size()); end
      drive_frame(8'hC3, CPB, 1'b1, NOLIMIT, s);
      tick(100);
      vectors++;
      if (rcv_cyc.size() !== 1 || rx_byte !== 8'hC3) begin miscompares++; $display("FAIL rstmid_next: got %0d pulses byte %h expected 1 pulse byte c3", rcv_cyc.size(), rx_byte); end
   endtask

   task automatic test_baud();
      int periods[2];
      int s;
      periods[0] = 101;
      periods[1] = 107;
      for (int i = 0; i < 2; i++) begin
         clear_events();
         drive_frame(8'h6D, periods[i], 1'b1, NOLIMIT, s);
         tick(100);
         vectors++;
         if (rcv_cyc.size() !== 1 || rx_byte !== 8'h6D || ferr_cyc.size() !== 0) begin
            miscompares++;
            $display("FAIL baud_%0d: got %0d pulses byte %h ferr %0d expected 1 pulse byte 6d ferr 0", periods[i], rcv_cyc.size(), rx_byte, ferr_cyc.size());
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] exp[$];
      logic [7:0] d;
      int s;
      clear_events();
      for (int i = 0; i < 12; i++) begin
         d = 8'($urandom);
         drive_frame(d, $urandom_range(101, 107), 1'b1, NOLIMIT, s);
         exp.push_back(d);
         tick($urandom_range(0, 150));
      end
      tick(150);
      vectors++;
      if (rcv_cyc.size() !== exp.size()) begin miscompares++; $display("FAIL rand_count: got %0d expected %0d", rcv_cyc.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < rcv_byte.size(); i++) begin
         vectors++;
         if (rcv_byte[i] !== exp[i]) begin miscompares++; $display("FAIL rand_byte%0d: got %h expected %h", i, rcv_byte[i], exp[i]); end
      end
      vectors++;
      if (ferr_cyc.size() !== 0) begin miscompares++; $display("FAIL rand_frame_err: got %0d expected 0", ferr_cyc.size()); end
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_break();
      test_reset_mid();
      test_baud();
      test_random();
      vectors++;
      if (overlap !== 0) begin miscompares++; $display("FAIL strobe_overlap: got %0d expected 0", overlap); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
